// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial bit stream, pattern programming and match status bundle
interface seq_detect_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               x;
  logic               x_valid;
  logic               overlap;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output x, x_valid, overlap, pat_load, pat_in,
    input  z, match_count, armed
  );

  modport slave (
    input  x, x_valid, overlap, pat_load, pat_in,
    output z, match_count, armed
  );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - programmable serial pattern detector with saturating match counter
module seq_detect_param #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b0110,
  parameter int                 CNT_W       = 8
) (
  input logic                clk,
  input logic                reset,
  seq_detect_param_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [PAT_LEN-1:0] pattern, pattern_n;
  logic [PAT_LEN-1:0] history, history_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               z_q, z_n;

  logic [PAT_LEN-1:0] new_hist;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  assign new_hist = {history[PAT_LEN-2:0], bus.x};
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
  assign match    = (state == ST_ARMED) && (new_hist == pattern);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      pattern <= DEFAULT_PAT;
      history <= '0;
      fill    <= '0;
      count   <= '0;
      z_q     <= 1'b0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      history <= history_n;
      fill    <= fill_n;
      count   <= count_n;
      z_q     <= z_n;
    end
  end

  always_comb begin
    pattern_n = pattern;
    history_n = history;
    fill_n    = fill;
    count_n   = count;
    z_n       = 1'b0;

    // A load restarts detection against the new pattern; any bit offered alongside it is dropped.
    if (bus.pat_load) begin
      pattern_n = bus.pat_in;
      history_n = '0;
      fill_n    = '0;
    end else if (bus.x_valid) begin
      history_n = new_hist;
      if (match) begin
        z_n = 1'b1;
        if (count != {CNT_W{1'b1}}) begin
          count_n = count + CNT_W'(1);
        end
        fill_n = bus.overlap ? fill_inc : '0;
      end else begin
        fill_n = fill_inc;
      end
    end

    if (fill_n == '0) begin
      state_n = ST_EMPTY;
    end else if (fill_n >= FILL_ARM) begin
      state_n = ST_ARMED;
    end else begin
      state_n = ST_FILLING;
    end
  end

  assign bus.z           = z_q;
  assign bus.match_count = count;
  assign bus.armed       = (state == ST_ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed vector bench for seq_detect_param
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(8)) bus  ();
  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(2)) bus2 ();

  seq_detect_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b0110), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_detect_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b0110), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    bit       rst;
    bit       v;
    bit       xb;
    bit       ld;
    bit [3:0] pin;
    bit       ov;
    bit       ez;
    int       ec;
    bit       ea;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit e_bits [13] = '{0,1,1,0,1,1,0,1,1,0,1,1,0};
  bit e_z    [13] = '{0,0,0,1,0,0,1,0,0,1,0,0,1};
  int e_cnt  [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,3};

  task automatic add(input bit rst, input bit v, input bit xb, input bit ld, input bit [3:0] pin,
                     input bit ov, input bit ez, input int ec, input bit ea);
    vec_t r;
    r.rst = rst; r.v = v; r.xb = xb; r.ld = ld; r.pin = pin; r.ov = ov;
    r.ez = ez; r.ec = ec; r.ea = ea;
    vecs.push_back(r);
  endtask

  task automatic step(input bit rst, input bit v, input bit xb, input bit ld, input bit [3:0] pin,
                      input bit ov);
    @(negedge clk);
    reset         = rst;
    bus.x_valid   = v;   bus2.x_valid  = v;
    bus.x         = xb;  bus2.x        = xb;
    bus.pat_load  = ld;  bus2.pat_load = ld;
    bus.pat_in    = pin; bus2.pat_in   = pin;
    bus.overlap   = ov;  bus2.overlap  = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.x = 0;  bus.x_valid = 0;  bus.overlap = 1;  bus.pat_load = 0;  bus.pat_in = '0;
    bus2.x = 0; bus2.x_valid = 0; bus2.overlap = 1; bus2.pat_load = 0; bus2.pat_in = '0;

    // overlapping detection of 0110 in 00110110
    add(1,0,0,0,4'h0,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    add(0,1,1,0,4'h0,1, 0,0,1);
    add(0,1,1,0,4'h0,1, 0,0,1);
    add(0,1,0,0,4'h0,1, 1,1,1);
    add(0,1,1,0,4'h0,1, 0,1,1);
    add(0,1,1,0,4'h0,1, 0,1,1);
    add(0,1,0,0,4'h0,1, 1,2,1);
    // same stream, non-overlapping
    add(1,0,0,0,4'h0,0, 0,0,0);
    add(0,1,0,0,4'h0,0, 0,0,0);
    add(0,1,0,0,4'h0,0, 0,0,0);
    add(0,1,1,0,4'h0,0, 0,0,1);
    add(0,1,1,0,4'h0,0, 0,0,1);
    add(0,1,0,0,4'h0,0, 1,1,0);
    add(0,1,1,0,4'h0,0, 0,1,0);
    add(0,1,1,0,4'h0,0, 0,1,0);
    add(0,1,0,0,4'h0,0, 0,1,1);
    // overlapping stream with invalid bubbles carrying junk bits
    add(1,0,0,0,4'h0,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    add(0,0,1,0,4'h0,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    add(0,0,1,0,4'h0,1, 0,0,0);
    add(0,0,1,0,4'h0,1, 0,0,0);
    add(0,1,1,0,4'h0,1, 0,0,1);
    add(0,0,0,0,4'h0,1, 0,0,1);
    add(0,0,0,0,4'h0,1, 0,0,1);
    add(0,0,1,0,4'h0,1, 0,0,1);
    add(0,1,1,0,4'h0,1, 0,0,1);
    add(0,1,0,0,4'h0,1, 1,1,1);
    add(0,0,0,0,4'h0,1, 0,1,1);
    add(0,1,1,0,4'h0,1, 0,1,1);
    add(0,1,1,0,4'h0,1, 0,1,1);
    add(0,0,0,0,4'h0,1, 0,1,1);
    add(0,0,1,0,4'h0,1, 0,1,1);
    add(0,1,0,0,4'h0,1, 1,2,1);
    // load 1111 with a valid 1 in the load cycle, then six 1s
    add(0,1,1,1,4'hF,1, 0,2,0);
    add(0,1,1,0,4'h0,1, 0,2,0);
    add(0,1,1,0,4'h0,1, 0,2,0);
    add(0,1,1,0,4'h0,1, 0,2,1);
    add(0,1,1,0,4'h0,1, 1,3,1);
    add(0,1,1,0,4'h0,1, 1,4,1);
    add(0,1,1,0,4'h0,1, 1,5,1);
    add(0,0,1,0,4'h0,1, 0,5,1);
    // reset mid-sequence discards 011
    add(1,0,0,0,4'h0,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    add(0,1,1,0,4'h0,1, 0,0,0);
    add(0,1,1,0,4'h0,1, 0,0,1);
    add(1,0,0,0,4'h0,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    // reset outranks a simultaneous load: default pattern still detected
    add(1,1,1,1,4'hF,1, 0,0,0);
    add(0,1,0,0,4'h0,1, 0,0,0);
    add(0,1,1,0,4'h0,1, 0,0,0);
    add(0,1,1,0,4'h0,1, 0,0,1);
    add(0,1,0,0,4'h0,1, 1,1,1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].xb, vecs[i].ld, vecs[i].pin, vecs[i].ov);
      chk($sformatf("vec%0d z", i),           32'(bus.z),           32'(vecs[i].ez));
      chk($sformatf("vec%0d match_count", i), 32'(bus.match_count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d armed", i),       32'(bus.armed),       32'(vecs[i].ea));
    end

    // 2-bit counter saturates at 3 while z keeps pulsing
    step(1,0,0,0,4'h0,1);
    chk("sat reset count", 32'(bus2.match_count), 32'd0);
    for (int i = 0; i < 13; i++) begin
      step(0,1,e_bits[i],0,4'h0,1);
      chk($sformatf("sat bit%0d z", i),     32'(bus2.z),           32'(e_z[i]));
      chk($sformatf("sat bit%0d count", i), 32'(bus2.match_count), 32'(e_cnt[i]));
    end
    step(0,0,0,0,4'h0,1);
    chk("sat bubble z", 32'(bus2.z), 32'd0);
    chk("sat hold count", 32'(bus2.match_count), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
